// File: rtl/pma_prbs_window_mon.sv
// pma_prbs_window_mon
// Receive-side PRBS measurement sequencer. It clears the PRBS checker counters,
// waits for checker lock, then runs back-to-back fixed-length windows. At each
// window end it snapshots the checker error/word counts and keeps run-level
// statistics (window count, peak window error, lock losses, lock timeout).
//
// Handshake: there is no valid/ready pair. win_valid_o is a one-cycle strobe
// that rises together with new win_err_o/win_words_o values. The consumer
// cannot stall it, and the values stay stable until the next strobe.
// The three *_clr_o outputs are one-cycle pulses that the checker acts on
// unconditionally.
module pma_prbs_window_mon #(
  parameter int WIN_W = 32,
  parameter int TMO_W = 32
) (
  input  logic             rx_clk_i,
  input  logic             rx_rst_n_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [1:0]       prbs_mode_rx_i,
  input  logic [WIN_W-1:0] window_len_i,
  input  logic [TMO_W-1:0] lock_timeout_i,
  input  logic             prbs_lock_state_i,
  input  logic [15:0]      prbs_error_cnt_i,
  input  logic [47:0]      prbs_bit_cnt_i,
  output logic             prbs_error_cnt_clr_o,
  output logic             prbs_bit_cnt_clr_o,
  output logic             prbs_not_locked_cnt_clr_o,
  output logic             busy_o,
  output logic             win_valid_o,
  output logic [15:0]      win_err_o,
  output logic [47:0]      win_words_o,
  output logic [31:0]      win_count_o,
  output logic [15:0]      max_win_err_o,
  output logic [15:0]      lock_loss_cnt_o,
  output logic             lock_timeout_err_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLR       = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_MEASURE   = 3'd3,
    S_SNAP      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             win_valid_q, win_valid_d;
  logic [15:0]      win_err_q, win_err_d;
  logic [47:0]      win_words_q, win_words_d;
  logic [31:0]      win_count_q, win_count_d;
  logic [15:0]      max_win_err_q, max_win_err_d;
  logic [15:0]      lock_loss_q, lock_loss_d;
  logic             tmo_err_q, tmo_err_d;
  logic             clr_pulse;

  // Abort condition: an explicit stop or the checker being switched off.
  logic             abort;
  // Last window-counter value of a window; a zero length behaves as one.
  logic [WIN_W-1:0] win_last;
  // Lock-wait expiry: only armed for a non-zero timeout.
  logic             tmo_hit;

  // Derived control terms used by the next-state logic.
  always_comb begin
    abort    = stop_i || (prbs_mode_rx_i == 2'b00);
    win_last = (window_len_i == '0) ? '0 : (window_len_i - WIN_W'(1));
    tmo_hit  = (lock_timeout_i != '0) && (tmo_cnt_q == (lock_timeout_i - TMO_W'(1)));
  end

  // Next-state, timers and result registers; abort is checked first in every busy state.
  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    win_valid_d   = 1'b0;
    win_err_d     = win_err_q;
    win_words_d   = win_words_q;
    win_count_d   = win_count_q;
    max_win_err_d = max_win_err_q;
    lock_loss_d   = lock_loss_q;
    tmo_err_d     = tmo_err_q;
    clr_pulse     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && (prbs_mode_rx_i != 2'b00)) begin
          state_d       = S_CLR;
          win_err_d     = '0;
          win_words_d   = '0;
          win_count_d   = '0;
          max_win_err_d = '0;
          lock_loss_d   = '0;
          tmo_err_d     = 1'b0;
        end
      end
      S_CLR: begin
        win_cnt_d = '0;
        tmo_cnt_d = '0;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          clr_pulse = 1'b1;
          state_d   = prbs_lock_state_i ? S_MEASURE : S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (prbs_lock_state_i) begin
          state_d = S_CLR;
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_MEASURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!prbs_lock_state_i) begin
          // Lock loss beats the window-end compare: the window is discarded.
          lock_loss_d = (lock_loss_q == 16'hFFFF) ? lock_loss_q : (lock_loss_q + 16'd1);
          state_d     = S_CLR;
        end else if (win_cnt_q == win_last) begin
          state_d = S_SNAP;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      S_SNAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          win_err_d     = prbs_error_cnt_i;
          win_words_d   = prbs_bit_cnt_i;
          win_valid_d   = 1'b1;
          win_count_d   = (win_count_q == 32'hFFFF_FFFF) ? win_count_q : (win_count_q + 32'd1);
          max_win_err_d = (prbs_error_cnt_i > max_win_err_q) ? prbs_error_cnt_i : max_win_err_q;
          state_d       = S_CLR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge rx_clk_i) begin
    if (!rx_rst_n_i) begin
      state_q       <= S_IDLE;
      win_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      win_valid_q   <= 1'b0;
      win_err_q     <= '0;
      win_words_q   <= '0;
      win_count_q   <= '0;
      max_win_err_q <= '0;
      lock_loss_q   <= '0;
      tmo_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      win_valid_q   <= win_valid_d;
      win_err_q     <= win_err_d;
      win_words_q   <= win_words_d;
      win_count_q   <= win_count_d;
      max_win_err_q <= max_win_err_d;
      lock_loss_q   <= lock_loss_d;
      tmo_err_q     <= tmo_err_d;
    end
  end

  // Output mapping; the clear pulses are shared by all three checker counters.
  always_comb begin
    prbs_error_cnt_clr_o      = clr_pulse;
    prbs_bit_cnt_clr_o        = clr_pulse;
    prbs_not_locked_cnt_clr_o = clr_pulse;
    busy_o                    = (state_q != S_IDLE);
    win_valid_o               = win_valid_q;
    win_err_o                 = win_err_q;
    win_words_o               = win_words_q;
    win_count_o               = win_count_q;
    max_win_err_o             = max_win_err_q;
    lock_loss_cnt_o           = lock_loss_q;
    lock_timeout_err_o        = tmo_err_q;
  end

endmodule

// File: tb/tb_pma_prbs_window_mon.sv
// Bench for pma_prbs_window_mon: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a phase/countdown model.
module tb_pma_prbs_window_mon;

  localparam int WIN_W = 32;
  localparam int TMO_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start, stop, lock;
  logic [1:0]       mode;
  logic [WIN_W-1:0] len;
  logic [TMO_W-1:0] tmo;
  logic [15:0]      err_cnt;
  logic [47:0]      bit_cnt;
  logic             err_clr, bit_clr, nl_clr, busy, win_valid, tmo_err;
  logic [15:0]      win_err, max_err, loss;
  logic [47:0]      win_words;
  logic [31:0]      win_count;

  pma_prbs_window_mon #(.WIN_W(WIN_W), .TMO_W(TMO_W)) dut (
    .rx_clk_i                  (clk),
    .rx_rst_n_i                (rst_n),
    .start_i                   (start),
    .stop_i                    (stop),
    .prbs_mode_rx_i            (mode),
    .window_len_i              (len),
    .lock_timeout_i            (tmo),
    .prbs_lock_state_i         (lock),
    .prbs_error_cnt_i          (err_cnt),
    .prbs_bit_cnt_i            (bit_cnt),
    .prbs_error_cnt_clr_o      (err_clr),
    .prbs_bit_cnt_clr_o        (bit_clr),
    .prbs_not_locked_cnt_clr_o (nl_clr),
    .busy_o                    (busy),
    .win_valid_o               (win_valid),
    .win_err_o                 (win_err),
    .win_words_o               (win_words),
    .win_count_o               (win_count),
    .max_win_err_o             (max_err),
    .lock_loss_cnt_o           (loss),
    .lock_timeout_err_o        (tmo_err)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases of a run; windows are tracked as remaining cycles, lock wait as elapsed cycles.
  localparam int P_IDLE = 0, P_CLEAR = 1, P_WAIT = 2, P_MEAS = 3, P_SNAP = 4;
  int          m_phase = P_IDLE;
  longint      m_left  = 0;
  longint      m_waited = 0;
  logic        m_valid = 1'b0;
  logic [15:0] m_err = '0, m_max = '0, m_loss = '0;
  logic [47:0] m_words = '0;
  logic [31:0] m_count = '0;
  logic        m_tmo_err = 1'b0;

  always @(posedge clk) begin : model
    logic off;
    off = stop || (mode == 2'b00);
    if (!rst_n) begin
      m_phase = P_IDLE; m_left = 0; m_waited = 0; m_valid = 1'b0;
      m_err = '0; m_max = '0; m_loss = '0; m_words = '0; m_count = '0; m_tmo_err = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_phase == P_IDLE) begin
        if (start && mode != 2'b00) begin
          m_err = '0; m_words = '0; m_count = '0; m_max = '0; m_loss = '0; m_tmo_err = 1'b0;
          m_phase = P_CLEAR;
        end
      end else if (off) begin
        m_phase = P_IDLE;
      end else begin
        case (m_phase)
          P_CLEAR: begin
            m_left   = (len == 0) ? 1 : longint'(len);
            m_waited = 0;
            m_phase  = lock ? P_MEAS : P_WAIT;
          end
          P_WAIT: begin
            if (lock) m_phase = P_CLEAR;
            else begin
              m_waited++;
              if (tmo != 0 && m_waited == longint'(tmo)) begin
                m_tmo_err = 1'b1;
                m_phase   = P_IDLE;
              end
            end
          end
          P_MEAS: begin
            if (!lock) begin
              if (m_loss != 16'hFFFF) m_loss = m_loss + 1;
              m_phase = P_CLEAR;
            end else begin
              m_left--;
              if (m_left == 0) m_phase = P_SNAP;
            end
          end
          default: begin
            m_err = err_cnt; m_words = bit_cnt; m_valid = 1'b1;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            if (err_cnt > m_max) m_max = err_cnt;
            m_phase = P_CLEAR;
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic clr_exp;
    if (check_en) begin
      clr_exp = (m_phase == P_CLEAR) && !(stop || mode == 2'b00);
      chk("busy", busy, m_phase != P_IDLE);
      chk("err_clr", err_clr, clr_exp);
      chk("bit_clr", bit_clr, clr_exp);
      chk("nl_clr", nl_clr, clr_exp);
      chk("win_valid", win_valid, m_valid);
      chk("win_err", win_err, m_err);
      chk("win_words", win_words, m_words);
      chk("win_count", win_count, m_count);
      chk("max_win_err", max_err, m_max);
      chk("lock_loss_cnt", loss, m_loss);
      chk("lock_timeout_err", tmo_err, m_tmo_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  // Cycles until win_valid is seen, bounded at 100.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (win_valid !== 1'b1 && n < 100);
    if (win_valid !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid: no win_valid within 100 cycles at %0t", $time);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [63:0] r64;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00; lock = 1'b0;
    len = 8; tmo = 0; err_cnt = '0; bit_cnt = '0;
    step(2);
    check_en = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_win_count", win_count, 0);
    chk("reset_valid", win_valid, 0);
    rst_n = 1'b1;

    // Basic windows: period 10 with window_len=8.
    mode = 2'b01; lock = 1'b1; len = 8; err_cnt = 16'd3; bit_cnt = 48'd1000;
    pulse_start();
    chk("clr_pulse", err_clr, 1);
    wait_valid(n);
    chk("first_latency", n, 10);
    chk("win1_err", win_err, 3);
    chk("win1_words", win_words, 1000);
    chk("win1_count", win_count, 1);
    chk("win1_max", max_err, 3);
    chk("model_win1_err", m_err, 3);
    err_cnt = 16'd1; bit_cnt = 48'd2000;
    wait_valid(n);
    chk("win_period", n, 10);
    chk("win2_err", win_err, 1);
    chk("win2_max", max_err, 3);
    chk("model_win2_max", m_max, 3);
    chk("win2_count", win_count, 2);
    wait_valid(n);
    chk("win3_count", win_count, 3);

    // Lock timeout.
    pulse_stop();
    chk("stop_idle", busy, 0);
    lock = 1'b0; tmo = 5;
    pulse_start();
    chk("start_zeroes_count", win_count, 0);
    step(5);
    chk("tmo_still_busy", busy, 1);
    chk("tmo_not_yet", tmo_err, 0);
    step(1);
    chk("tmo_busy", busy, 0);
    chk("tmo_err", tmo_err, 1);
    chk("tmo_no_clr", err_clr, 0);
    chk("model_tmo_err", m_tmo_err, 1);

    // Lock drop at measure cycle 4.
    tmo = 0; lock = 1'b1; len = 8; err_cnt = 16'd2;
    pulse_start();
    step(4);
    lock = 1'b0;
    step(1);
    chk("drop_loss", loss, 1);
    chk("drop_no_valid", win_valid, 0);
    chk("drop_clr", err_clr, 1);
    chk("drop_tmo_cleared", tmo_err, 0);
    step(1);
    chk("drop_waiting", busy, 1);
    step(3);
    lock = 1'b1;
    wait_valid(n);
    chk("relock_latency", n, 11);
    chk("relock_count", win_count, 1);
    chk("relock_loss", loss, 1);

    // Stop during SNAP.
    pulse_stop();
    err_cnt = 16'd5;
    pulse_start();
    wait_valid(n);
    chk("pre_stop_err", win_err, 5);
    err_cnt = 16'd7;
    step(9);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("snapstop_busy", busy, 0);
    chk("snapstop_valid", win_valid, 0);
    chk("snapstop_err", win_err, 5);
    chk("snapstop_count", win_count, 1);
    step(1);
    chk("snapstop_valid2", win_valid, 0);

    // Mode forced off mid-window.
    pulse_start();
    wait_valid(n);
    chk("pre_mode_err", win_err, 7);
    err_cnt = 16'd9;
    step(4);
    mode = 2'b00; step(1); mode = 2'b01;
    chk("modeoff_busy", busy, 0);
    chk("modeoff_err", win_err, 7);
    step(12);
    chk("modeoff_count", win_count, 1);

    // window_len = 0 behaves as 1.
    len = 0;
    pulse_start();
    wait_valid(n);
    chk("len0_latency", n, 3);
    wait_valid(n);
    chk("len0_period", n, 3);
    chk("len0_count", win_count, 2);

    // Reset mid-measure.
    pulse_stop();
    len = 8;
    pulse_start();
    wait_valid(n);
    step(4);
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_count", win_count, 0);
    chk("midrst_err", win_err, 0);
    chk("midrst_words", win_words, 0);
    chk("midrst_max", max_err, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (m_phase == P_IDLE && $urandom_range(0, 3) == 0) begin
        len = $urandom_range(0, 12);
        tmo = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      end
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 199) == 0);
      mode  = ($urandom_range(0, 99) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) lock = ~lock;
      err_cnt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      r64 = {$urandom, $urandom};
      bit_cnt = r64[47:0];
      rst_n = ($urandom_range(0, 499) != 0);
      step(1);
    end
    start = 1'b0; stop = 1'b0; rst_n = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
